// File: rtl/w_addr_sequencer_pkg.sv
// Shared FFT definitions: helper clog2, stage-ordering modes and
// sequencer state encoding.
package w_addr_sequencer_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam bit MODE_DIT = 1'b0;
    localparam bit MODE_DIF = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIN  = ST_FIN
    } seq_state_e;

endpackage

// File: rtl/w_addr_sequencer_fft_stage_counter.sv
// Butterfly/stage counter pair for an iterative radix-2 FFT:
// b runs 0..N/2-1, then wraps and advances s; s wraps after N_LOG2-1.
module w_addr_sequencer_fft_stage_counter #(
    parameter int N_LOG2 = 6,
    parameter int SW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [N_LOG2-2:0] b_o,
    output logic [SW-1:0]     s_o,
    output logic              last_bf_o
);

    logic [N_LOG2-2:0] b_q;
    logic [SW-1:0]     s_q;
    logic              s_last;

    assign last_bf_o = &b_q;
    assign s_last    = (s_q == SW'(N_LOG2 - 1));
    assign b_o       = b_q;
    assign s_o       = s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
            s_q <= '0;
        end else if (clr_i) begin
            b_q <= '0;
            s_q <= '0;
        end else if (en_i) begin
            if (last_bf_o) begin
                b_q <= '0;
                s_q <= s_last ? '0 : s_q + 1'b1;
            end else begin
                b_q <= b_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/w_addr_sequencer.sv
// Self-sequencing twiddle-address generator for the radix-2 FFT core,
// DIT/DIF ordering, forward/inverse, valid/ready paced output.
module w_addr_sequencer
    import w_addr_sequencer_pkg::*;
#(
    parameter int N_LOG2 = 6,
    parameter bit DIF    = 1'b0,
    parameter int AWL    = N_LOG2 - 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_START,
    input  logic                       i_INV,
    input  logic                       i_CLR,
    input  logic                       i_READY,
    output logic                       o_VALID,
    output logic [AWL-1:0]             o_W_ADDR,
    output logic                       o_CONJ,
    output logic [clog2(N_LOG2)-1:0]   o_STAGE,
    output logic                       o_LAST_BF,
    output logic                       o_BUSY,
    output logic                       o_DONE
);

    localparam int SW = clog2(N_LOG2);

    seq_state_e         state_q;
    logic               inv_q;
    logic [AWL-1:0]     cnt_b;
    logic [SW-1:0]      cnt_s;
    logic               cnt_last_bf;
    logic               final_beat;
    logic               start_acc;
    logic               step;
    logic               load;
    logic [AWL-1:0]     k_d;
    int                 mw;
    int                 sh;
    int                 kw;

    // The counter always points at the next beat to present, so a
    // load copies it into the output registers and advances it.
    w_addr_sequencer_fft_stage_counter #(
        .N_LOG2 (N_LOG2),
        .SW     (SW)
    ) u_cnt (
        .clk       (CLK),
        .rst_n     (RST),
        .clr_i     (i_CLR),
        .en_i      (load),
        .b_o       (cnt_b),
        .s_o       (cnt_s),
        .last_bf_o (cnt_last_bf)
    );

    assign final_beat = o_LAST_BF && (o_STAGE == SW'(N_LOG2 - 1));
    assign start_acc  = (state_q != RUN) && i_START && !i_CLR;
    assign step       = (state_q == RUN) && i_READY && !final_beat && !i_CLR;
    assign load       = start_acc || step;

    always_comb begin
        mw = 0;
        sh = 0;
        if (DIF == MODE_DIF) begin
            mw = AWL - int'(cnt_s);
            sh = int'(cnt_s);
        end else begin
            mw = int'(cnt_s);
            sh = AWL - int'(cnt_s);
        end
        kw  = (int'(cnt_b) & ((1 << mw) - 1)) << sh;
        k_d = AWL'(kw);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            inv_q     <= 1'b0;
            o_VALID   <= 1'b0;
            o_W_ADDR  <= '0;
            o_CONJ    <= 1'b0;
            o_STAGE   <= '0;
            o_LAST_BF <= 1'b0;
            o_BUSY    <= 1'b0;
            o_DONE    <= 1'b0;
        end else if (i_CLR) begin
            state_q   <= IDLE;
            o_VALID   <= 1'b0;
            o_W_ADDR  <= '0;
            o_STAGE   <= '0;
            o_LAST_BF <= 1'b0;
            o_BUSY    <= 1'b0;
            o_DONE    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, FIN: begin
                    o_DONE <= 1'b0;
                    if (i_START) begin
                        state_q   <= RUN;
                        inv_q     <= i_INV;
                        o_VALID   <= 1'b1;
                        o_BUSY    <= 1'b1;
                        o_W_ADDR  <= k_d;
                        o_CONJ    <= i_INV;
                        o_STAGE   <= cnt_s;
                        o_LAST_BF <= cnt_last_bf;
                    end else begin
                        state_q <= IDLE;
                        o_VALID <= 1'b0;
                        o_BUSY  <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_READY) begin
                        if (final_beat) begin
                            state_q <= FIN;
                            o_VALID <= 1'b0;
                            o_BUSY  <= 1'b0;
                            o_DONE  <= 1'b1;
                        end else begin
                            o_W_ADDR  <= k_d;
                            o_CONJ    <= inv_q;
                            o_STAGE   <= cnt_s;
                            o_LAST_BF <= cnt_last_bf;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    o_VALID <= 1'b0;
                    o_BUSY  <= 1'b0;
                    o_DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w_addr_sequencer.sv
// Bench for w_addr_sequencer: N=8 DIT, N=8 DIF and N=64 DIT instances
// share inputs and are checked every cycle against a beat-level model.
module tb_w_addr_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic start = 1'b0;
    logic inv = 1'b0;
    logic clr = 1'b0;
    logic ready = 1'b0;

    always #5 CLK = ~CLK;

    logic       a_valid, a_conj, a_last, a_busy, a_done;
    logic [1:0] a_addr, a_stage;
    logic       b_valid, b_conj, b_last, b_busy, b_done;
    logic [1:0] b_addr, b_stage;
    logic       c_valid, c_conj, c_last, c_busy, c_done;
    logic [4:0] c_addr;
    logic [2:0] c_stage;

    w_addr_sequencer #(.N_LOG2(3), .DIF(1'b0)) u_a (
        .CLK(CLK), .RST(RST), .i_START(start), .i_INV(inv),
        .i_CLR(clr), .i_READY(ready), .o_VALID(a_valid),
        .o_W_ADDR(a_addr), .o_CONJ(a_conj), .o_STAGE(a_stage),
        .o_LAST_BF(a_last), .o_BUSY(a_busy), .o_DONE(a_done)
    );

    w_addr_sequencer #(.N_LOG2(3), .DIF(1'b1)) u_b (
        .CLK(CLK), .RST(RST), .i_START(start), .i_INV(inv),
        .i_CLR(clr), .i_READY(ready), .o_VALID(b_valid),
        .o_W_ADDR(b_addr), .o_CONJ(b_conj), .o_STAGE(b_stage),
        .o_LAST_BF(b_last), .o_BUSY(b_busy), .o_DONE(b_done)
    );

    w_addr_sequencer #(.N_LOG2(6)) u_c (
        .CLK(CLK), .RST(RST), .i_START(start), .i_INV(inv),
        .i_CLR(clr), .i_READY(ready), .o_VALID(c_valid),
        .o_W_ADDR(c_addr), .o_CONJ(c_conj), .o_STAGE(c_stage),
        .o_LAST_BF(c_last), .o_BUSY(c_busy), .o_DONE(c_done)
    );

    int total = 0;
    int bad = 0;

    int nl[3] = '{3, 3, 6};
    bit df[3] = '{1'b0, 1'b1, 1'b0};
    bit m_run[3];
    bit m_done[3];
    bit m_inv[3];
    int m_beat[3];

    int hs_a[$];
    int hs_b[$];
    int hs_c_n = 0;
    int dn_a = 0;

    int exp_dit[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int exp_dif[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    function automatic int nbeats(input int i);
        return nl[i] * (1 << (nl[i] - 1));
    endfunction

    function automatic int kref(input int i, input int j);
        int half, s, b;
        half = 1 << (nl[i] - 1);
        s = j / half;
        b = j % half;
        if (df[i]) return (b % (1 << (nl[i] - 1 - s))) * (1 << s);
        return (b % (1 << s)) * (1 << (nl[i] - 1 - s));
    endfunction

    task automatic mstep();
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                m_run[i] = 1'b0;
                m_done[i] = 1'b0;
                m_beat[i] = 0;
            end else if (m_run[i]) begin
                m_done[i] = 1'b0;
                if (ready) begin
                    if (m_beat[i] == nbeats(i) - 1) begin
                        m_run[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end else begin
                        m_beat[i]++;
                    end
                end
            end else begin
                m_done[i] = 1'b0;
                if (start) begin
                    m_run[i] = 1'b1;
                    m_beat[i] = 0;
                    m_inv[i] = inv;
                end
            end
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 1'b0;
            m_done[i] = 1'b0;
            m_inv[i] = 1'b0;
            m_beat[i] = 0;
        end
    endtask

    task automatic cmp_one(input int i, input int v, input int bz,
                           input int dn, input int k, input int cj,
                           input int st, input int lb);
        int half;
        half = 1 << (nl[i] - 1);
        chk($sformatf("u%0d.valid", i), v, int'(m_run[i]));
        chk($sformatf("u%0d.busy", i), bz, int'(m_run[i]));
        chk($sformatf("u%0d.done", i), dn, int'(m_done[i]));
        if (m_run[i]) begin
            chk($sformatf("u%0d.k@%0d", i, m_beat[i]), k,
                kref(i, m_beat[i]));
            chk($sformatf("u%0d.conj", i), cj, int'(m_inv[i]));
            chk($sformatf("u%0d.stage", i), st, m_beat[i] / half);
            chk($sformatf("u%0d.last", i), lb,
                int'((m_beat[i] % half) == half - 1));
        end
    endtask

    task automatic check_all();
        cmp_one(0, a_valid, a_busy, a_done, a_addr, a_conj, a_stage, a_last);
        cmp_one(1, b_valid, b_busy, b_done, b_addr, b_conj, b_stage, b_last);
        cmp_one(2, c_valid, c_busy, c_done, c_addr, c_conj, c_stage, c_last);
        if (a_done) dn_a++;
    endtask

    task automatic tick();
        if (a_valid && ready) hs_a.push_back(int'(a_addr));
        if (b_valid && ready) hs_b.push_back(int'(b_addr));
        if (c_valid && ready) hs_c_n++;
        @(posedge CLK);
        mstep();
        #1;
        check_all();
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, ".a_valid"}, a_valid, 0);
        chk({tag, ".a_busy"}, a_busy, 0);
        chk({tag, ".a_done"}, a_done, 0);
        chk({tag, ".a_addr"}, a_addr, 0);
        chk({tag, ".a_conj"}, a_conj, 0);
        chk({tag, ".a_stage"}, a_stage, 0);
        chk({tag, ".a_last"}, a_last, 0);
        chk({tag, ".c_valid"}, c_valid, 0);
        chk({tag, ".c_addr"}, c_addr, 0);
        chk({tag, ".c_stage"}, c_stage, 0);
        chk({tag, ".c_busy"}, c_busy, 0);
    endtask

    task automatic seq_chk(input string tag);
        chk({tag, ".n_dit"}, hs_a.size(), 12);
        chk({tag, ".n_dif"}, hs_b.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s.dit%0d", tag, i),
                (i < hs_a.size()) ? hs_a[i] : -1, exp_dit[i]);
            chk($sformatf("%s.dif%0d", tag, i),
                (i < hs_b.size()) ? hs_b[i] : -1, exp_dif[i]);
        end
    endtask

    initial begin
        int phase;
        mreset();
        #2;
        zero_chk("reset");
        #10;
        RST = 1'b1;

        // plain forward transform, ready held high
        hs_a.delete();
        hs_b.delete();
        dn_a = 0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        seq_chk("fwd");
        chk("fwd.done_cnt", dn_a, 1);

        // stall at the sixth beat
        hs_a.delete();
        hs_b.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall.k%0d", i), a_addr, 2);
            chk($sformatf("stall.s%0d", i), a_stage, 1);
        end
        ready = 1'b1;
        repeat (8) tick();
        seq_chk("stall");

        // inverse run with i_INV/i_START noise mid-transform
        inv = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        inv = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        inv = 1'b1;
        repeat (3) tick();
        chk("inv.conj_mid", a_conj, 1);
        inv = 1'b0;
        repeat (7) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("inv.conj_fwd", a_conj, 0);
        repeat (13) tick();

        // abort at the seventh beat; start in same cycle is ignored
        dn_a = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        clr = 1'b1;
        start = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b0;
        chk("clr.valid", a_valid, 0);
        chk("clr.busy", a_busy, 0);
        repeat (3) tick();
        chk("clr.no_done", dn_a, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clr.restart_k", a_addr, 0);
        chk("clr.restart_s", a_stage, 0);
        repeat (13) tick();

        // asynchronous reset in the middle of a cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #3;
        RST = 1'b0;
        mreset();
        #1;
        zero_chk("arst");
        #2;
        RST = 1'b1;
        repeat (2) tick();

        // N=64 with random ready, then back-to-back start in FIN
        hs_c_n = 0;
        phase = 0;
        inv = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ready = ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 1) != 0);
            tick();
            if (m_done[2]) begin
                phase++;
                if (phase == 2) break;
                start = 1'b1;
                inv = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("rand.transforms", phase, 2);
        chk("rand.beats", hs_c_n, 384);
        ready = 1'b1;
        repeat (16) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
